aes128_key_schedule: RTL

Sequential AES-128 key expansion engine for the decryption datapath. It accepts a 128-bit cipher key and produces the 11 round keys, one per clock, using a single `g_function` instance on the last word of the previous round key. The round keys are held in an internal register file. A registered random-access read port serves them to the inverse-round pipeline, which reads them in reverse order (round 10 down to 0).

---
 rtl/aes_pkg.sv | 31 +++
 rtl/g_function.sv | 10 +
 rtl/aes128_key_schedule.sv | 56 +++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, the key-schedule state encoding and the S-box function
package aes_pkg;
  localparam int AES_KEY_W = 128;
  localparam int AES128_NR = 10;
  typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_t;
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s = x;
    logic [7:0] p = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      p = gf_mul(p, s);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/g_function.sv
// g_function: RotWord, SubWord and Rcon xor of the last word of a round key
module g_function
  import aes_pkg::*;
(
  input  logic [31:0] w,
  input  logic [7:0]  rcon,
  output logic [31:0] t
);
  always_comb t = {sbox(w[23:16]) ^ rcon, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
endmodule

// File: rtl/aes128_key_schedule.sv
// aes128_key_schedule: sequential AES-128 key expansion with a registered random-access round-key read port
module aes128_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] cipher_key,
  output logic                 busy,
  output logic                 key_ready,
  input  logic [3:0]           rd_round,
  output logic [AES_KEY_W-1:0] rd_key
);
  ks_state_t state, state_nx;
  logic [3:0] rnd;
  logic [AES_KEY_W-1:0] work, nk;
  logic [AES_KEY_W-1:0] keys [NR+1];
  logic [31:0] t, n0, n1, n2, n3;
  logic accept, last;
  g_function u_g (.w(work[31:0]), .rcon(RCON[rnd]), .t(t));
  always_comb begin
    n0 = work[127:96] ^ t;
    n1 = work[95:64] ^ n0;
    n2 = work[63:32] ^ n1;
    n3 = work[31:0] ^ n2;
    nk = {n0, n1, n2, n3};
    accept = start && state != EXPAND;
    last = state == EXPAND && rnd == 4'(NR);
    state_nx = accept ? EXPAND : last ? READY : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd <= '0;
      work <= '0;
      rd_key <= '0;
      for (int i = 0; i <= NR; i++) keys[i] <= '0;
    end else begin
      state <= state_nx;
      rd_key <= rd_round <= 4'(NR) ? keys[rd_round] : '0;
      if (accept) begin
        keys[0] <= cipher_key;
        work <= cipher_key;
        rnd <= 4'd1;
      end else if (state == EXPAND) begin
        keys[rnd] <= nk;
        work <= nk;
        rnd <= last ? rnd : rnd + 4'd1;
      end
    end
  end
  assign busy = state == EXPAND;
  assign key_ready = state == READY;
endmodule
